// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_arbiter
// Purpose  : Round-robin arbiter sharing one register-file write port and one
//            read mux among NREQ requesters; reads return after two cycles.
// Revision : 1.0
// ============================================================================
module regfile_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*5-1:0]       req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [WIDTH-1:0]        rf_wdata,
  output logic [4:0]              rf_rsel,
  input  logic [WIDTH-1:0]        rf_rdata,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_data
);

  localparam int c_IDW = $clog2(NREQ);

  // (base + off) mod NREQ, valid for off < NREQ and base < NREQ
  function automatic logic [c_IDW-1:0] f_wrap(input logic [c_IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return c_IDW'(sum);
  endfunction

  logic [4:0]       w_addr  [NREQ];
  logic [WIDTH-1:0] w_wdata [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign w_addr[gi]  = req_addr[gi*5 +: 5];
      assign w_wdata[gi] = req_wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [c_IDW-1:0] r_ptr;
  logic             w_gnt_any;
  logic [c_IDW-1:0] w_gnt_idx;
  logic             w_gnt_valid;

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_any && req_valid[f_wrap(r_ptr, k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = f_wrap(r_ptr, k);
      end
    end
  end

  // Reset suppresses the grant so no transfer is accepted while held in reset
  assign w_gnt_valid = w_gnt_any & rst_n;

  always_comb begin
    req_ready = '0;
    if (w_gnt_valid) req_ready[w_gnt_idx] = 1'b1;
  end

  logic             w_g_we;
  logic [4:0]       w_g_addr;
  logic [WIDTH-1:0] w_g_wdata;
  logic             w_wr_commit;
  logic             w_rd_issue;

  assign w_g_we    = req_we[w_gnt_idx];
  assign w_g_addr  = w_addr[w_gnt_idx];
  assign w_g_wdata = w_wdata[w_gnt_idx];

  // Register 0 is read-only: the write is accepted but never reaches the file
  assign w_wr_commit = w_gnt_valid & w_g_we & (w_g_addr != 5'd0);
  assign w_rd_issue  = w_gnt_valid & ~w_g_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_gnt_valid) begin
      r_ptr <= f_wrap(w_gnt_idx, 1);
    end
  end

  logic             r_rf_we;
  logic [4:0]       r_rf_waddr;
  logic [WIDTH-1:0] r_rf_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_wr_commit;
      if (w_wr_commit) begin
        r_rf_waddr <= w_g_addr;
        r_rf_wdata <= w_g_wdata;
      end
    end
  end

  logic             r_rsel;
  logic [4:0]       r_rf_rsel;
  logic [c_IDW-1:0] r_rd_id;
  logic             r_rd_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rf_rsel <= '0;
      r_rd_id   <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_issue;
      if (w_rd_issue) begin
        r_rf_rsel <= w_g_addr;
        r_rd_id   <= w_gnt_idx;
      end
    end
  end

  assign r_rsel = r_rd_pend;

  logic             r_rsp_valid;
  logic [c_IDW-1:0] r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;

  // Capture happens after any write issued one cycle earlier has committed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= r_rsel;
      if (r_rsel) begin
        r_rsp_id   <= r_rd_id;
        r_rsp_data <= rf_rdata;
      end
    end
  end

  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign rf_rsel   = r_rf_rsel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the register data width.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters sharing the register file.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-005 req_valid  input  NREQ  SHALL be the per-requester request-valid bit.
REQ-006 req_we  input  NREQ  SHALL select the operation per requester: 1 = write, 0 = read.
REQ-007 req_addr  input  NREQ*5  SHALL carry the register address per requester; requester i uses bits [5i+4:5i].
REQ-008 req_wdata  input  NREQ*WIDTH  SHALL carry the write data per requester, packed the same way.
REQ-009 req_ready  output  NREQ  SHALL be the one-hot grant. Requester i transfers in the cycle where req_valid[i] and req_ready[i] are both high.
REQ-010 rf_we  output  1  SHALL be the register file write enable.
REQ-011 rf_waddr  output  5  SHALL be the register file write address.
REQ-012 rf_wdata  output  WIDTH  SHALL be the register file write data.
REQ-013 rf_rsel  output  5  SHALL drive the register file read-mux select.
REQ-014 rf_rdata  input  WIDTH  SHALL be the combinational read-mux output for rf_rsel.
REQ-015 rsp_valid  output  1  SHALL pulse for one cycle per completed read.
REQ-016 rsp_id  output  $clog2(NREQ)  SHALL carry the index of the requester that issued the read.
REQ-017 rsp_data  output  WIDTH  SHALL carry the read data.

Function
REQ-018 At most one request SHALL be granted per cycle.
- req_ready is combinational from req_valid and the round-robin pointer.
- req_ready is all-zero when req_valid is all-zero.
REQ-019 The grant SHALL go to the first valid requester found searching ascending from the pointer, with wrap modulo NREQ.
REQ-020 On any grant to requester g, the pointer SHALL update to (g+1) mod NREQ. With no grant, the pointer SHALL hold.
REQ-021 Write granted in cycle T (address != 0): rf_we SHALL be 1 during T+1 only, with rf_waddr/rf_wdata registered from requester g.
REQ-022 Write granted in cycle T to address 0:
- The write SHALL still be granted (req_ready high).
- rf_we SHALL stay 0 in T+1, because register 0 is read-only.
REQ-023 Read granted in cycle T:
- rf_rsel SHALL take the requester's address during T+1.
- rf_rdata SHALL be captured at the end of T+1.
- rsp_valid=1, rsp_id=g and rsp_data SHALL be presented during T+2.
- Fixed latency is 2 cycles, with no response backpressure.
REQ-024 rf_rsel SHALL hold its last value when no read is granted.
REQ-025 rsp_data and rsp_id SHALL hold their last values while rsp_valid=0.
REQ-026 A write granted in T followed by a read to the same address granted in T+1 SHALL return the new data, since the write commits at the end of T+1, before the read captures at the end of T+2.
REQ-027 Back-to-back reads SHALL be fully pipelined at one grant per cycle. Any interleaving of reads and writes SHALL sustain one grant per cycle.
REQ-028 A requester holding req_valid high SHALL be granted within NREQ cycles (no starvation).

Reset
REQ-029 While rst_n=0 at a rising edge, the block SHALL set:
- pointer=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_rsel=0;
- rsp_valid=0, rsp_id=0, rsp_data=0;
- all in-flight reads and writes discarded.
REQ-030 req_ready SHALL be all-zero whenever rst_n=0.
REQ-031 No rf_we or rsp_valid pulse SHALL appear in the cycles after reset for requests granted before reset.

Verification
REQ-032 The bench SHALL cover single write then read, requester 1:
- Stimulus: write addr 5 = 0xDEADBEEF in cycle T, then read addr 5 in T+1.
- Required: rf_we=1, rf_waddr=5 in T+1; rsp_valid=1, rsp_id=1, rsp_data=0xDEADBEEF in T+3.
REQ-033 The bench SHALL cover round-robin fairness:
- Stimulus: all 4 requesters hold read requests continuously from reset.
- Required: grant order 0,1,2,3,0,1,...; each requester is granted every 4 cycles.
REQ-034 The bench SHALL cover pointer wrap:
- Stimulus: only requesters 3 and 0 valid, pointer=3.
- Required: grant 3, then 0, then 3.
REQ-035 The bench SHALL cover the address-0 write:
- Stimulus: requester 2 writes 0x1234 to addr 0, then reads addr 0.
- Required: req_ready[2]=1, rf_we stays 0, and the read returns the register file value of register 0 (0 in the bench).
REQ-036 The bench SHALL cover reset mid-operation:
- Stimulus: read granted in T, rst_n=0 in T+1.
- Required: rsp_valid stays 0 in T+2, and pointer=0 after reset.
REQ-037 The bench SHALL cover the idle cycle:
- Stimulus: req_valid=0 for 3 cycles.
- Required: req_ready=0, rf_we=0, rsp_valid=0, and rf_rsel holds its last value.
